// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// Holds the FSM state encoding, the grant identifier and the round-robin pick.
package cache_arbiter_pkg;

    localparam int unsigned LINE_W_DEF = 256;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_RELEASE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    // Only meaningful when at least one side is pending; on contention the side not served last wins.
    function automatic arb_grant_t rr_pick(input logic i_pend, input logic d_pend, input arb_grant_t last);
        if (i_pend && d_pend) begin
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_pend) begin
            return GRANT_D;
        end else begin
            return GRANT_I;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the cacheline adaptor.
// slave: the arbiter's view; master: the caches/memory environment view.
interface cache_arbiter_if
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache with round-robin on contention.
// The granted request is latched and held on the memory port until pmem_resp.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic           clk,
    input logic           rst,
    cache_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    arb_grant_t        last_grant_q, pick;
    logic              load;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_pend, d_pend;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;
    assign pick   = rr_pick(i_pend, d_pend, last_grant_q);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (i_pend || d_pend) begin
                    load    = 1'b1;
                    state_d = (pick == GRANT_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch: d_read wins over d_write when both are (illegally) asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else if (load) begin
            last_grant_q <= pick;
            if (pick == GRANT_D) begin
                addr_q  <= bus.d_address;
                wdata_q <= bus.d_wdata;
                write_q <= bus.d_write & ~bus.d_read;
            end else begin
                addr_q  <= bus.i_address;
                wdata_q <= '0;
                write_q <= 1'b0;
            end
        end
    end

    // Strobes decode from the registered state, so an async reset drops them immediately.
    assign bus.pmem_read    = (state_q == ARB_SERVE_I) || ((state_q == ARB_SERVE_D) && !write_q);
    assign bus.pmem_write   = (state_q == ARB_SERVE_D) && write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_resp  = (state_q == ARB_SERVE_I) && bus.pmem_resp;
    assign bus.d_resp  = (state_q == ARB_SERVE_D) && bus.pmem_resp;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(bus.d_read && bus.d_write));
    a_resp_in_serve:  assert property (@(posedge clk) disable iff (!rst)
                                       bus.pmem_resp |-> (state_q == ARB_SERVE_I || state_q == ARB_SERVE_D));
    a_strobe_onehot:  assert property (@(posedge clk) disable iff (!rst) !(bus.pmem_read && bus.pmem_write));
    a_resp_onehot:    assert property (@(posedge clk) disable iff (!rst) !(bus.i_resp && bus.d_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single requests, contention, round-robin,
// request-latch stability and asynchronous reset mid-transaction.
module tb_cache_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;
    localparam logic [LW-1:0] LINE_AB = {8{32'hABAB_ABAB}};
    localparam logic [LW-1:0] LINE_55 = {8{32'h5555_5555}};
    localparam logic [LW-1:0] LINE_C3 = {8{32'hC3C3_C3C3}};
    localparam logic [LW-1:0] LINE_17 = {8{32'h1717_1717}};

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp_on(input logic [LW-1:0] data);
        bus.pmem_rdata = data;
        bus.pmem_resp  = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        tick();
        tick();
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset pmem_read: got %b want 0", bus.pmem_read); end
        vectors++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL reset pmem_write: got %b want 0", bus.pmem_write); end
        vectors++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL reset pmem_address: got %h want 0", bus.pmem_address); end
        vectors++; if (bus.pmem_wdata !== '0) begin errors++; $display("FAIL reset pmem_wdata: got %h want 0", bus.pmem_wdata); end
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin errors++; $display("FAIL reset resp: got %b want 00", {bus.i_resp, bus.d_resp}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL i_read early strobe: got %b want 0", bus.pmem_read); end
        tick();
        vectors++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL i_read strobe: got %b want 1", bus.pmem_read); end
        vectors++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL i_read write strobe: got %b want 0", bus.pmem_write); end
        vectors++; if (bus.pmem_address !== 32'h40) begin errors++; $display("FAIL i_read addr: got %h want 40", bus.pmem_address); end
        vectors++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL i_read resp before mem: got %b want 0", bus.i_resp); end
        resp_on(LINE_AB);
        vectors++; if (bus.i_resp !== 1'b1) begin errors++; $display("FAIL i_read i_resp: got %b want 1", bus.i_resp); end
        vectors++; if (bus.d_resp !== 1'b0) begin errors++; $display("FAIL i_read d_resp: got %b want 0", bus.d_resp); end
        vectors++; if (bus.i_rdata !== LINE_AB) begin errors++; $display("FAIL i_read rdata: got %h want %h", bus.i_rdata, LINE_AB); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        #1;
        vectors++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL i_read resp width: got %b want 0", bus.i_resp); end
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL i_read release strobe: got %b want 0", bus.pmem_read); end
        tick();
    endtask

    task automatic test_d_write();
        bus.d_write = 1'b1; bus.d_address = 32'h0000_1000; bus.d_wdata = LINE_55;
        tick();
        vectors++; if (bus.pmem_write !== 1'b1) begin errors++; $display("FAIL d_write strobe: got %b want 1", bus.pmem_write); end
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL d_write read strobe: got %b want 0", bus.pmem_read); end
        vectors++; if (bus.pmem_address !== 32'h1000) begin errors++; $display("FAIL d_write addr: got %h want 1000", bus.pmem_address); end
        vectors++; if (bus.pmem_wdata !== LINE_55) begin errors++; $display("FAIL d_write wdata: got %h want %h", bus.pmem_wdata, LINE_55); end
        resp_on('0);
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin errors++; $display("FAIL d_write resp: got %b want 01", {bus.i_resp, bus.d_resp}); end
        tick();
        bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
        #1;
        vectors++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin errors++; $display("FAIL d_write release strobes: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
        tick();
    endtask

    task automatic test_contention();
        rst = 1'b0;
        tick();
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
        bus.d_read = 1'b1; bus.d_address = 32'h0000_2000;
        rst = 1'b1;
        tick();
        vectors++; if (bus.pmem_address !== 32'h2000) begin errors++; $display("FAIL contention first addr: got %h want 2000", bus.pmem_address); end
        vectors++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL contention first strobe: got %b want 1", bus.pmem_read); end
        resp_on(LINE_C3);
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin errors++; $display("FAIL contention first resp: got %b want 01", {bus.i_resp, bus.d_resp}); end
        vectors++; if (bus.d_rdata !== LINE_C3) begin errors++; $display("FAIL contention d_rdata: got %h want %h", bus.d_rdata, LINE_C3); end
        tick();
        bus.pmem_resp = 1'b0; bus.d_read = 1'b0;
        #1;
        vectors++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin errors++; $display("FAIL contention release strobes: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
        tick();
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL contention idle strobe: got %b want 0", bus.pmem_read); end
        tick();
        vectors++; if (bus.pmem_address !== 32'h40 || bus.pmem_read !== 1'b1) begin errors++; $display("FAIL contention second grant: got addr %h rd %b want addr 40 rd 1", bus.pmem_address, bus.pmem_read); end
        resp_on(LINE_17);
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b10) begin errors++; $display("FAIL contention second resp: got %b want 10", {bus.i_resp, bus.d_resp}); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr;
        logic [1:0]    exp_resp;
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
        bus.d_read = 1'b1; bus.d_address = 32'h0000_2000;
        for (int n = 0; n < 4; n++) begin
            exp_addr = (n % 2 == 0) ? 32'h2000 : 32'h40;
            exp_resp = (n % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            vectors++; if (bus.pmem_address !== exp_addr) begin errors++; $display("FAIL rr grant %0d addr: got %h want %h", n, bus.pmem_address, exp_addr); end
            resp_on(LINE_AB);
            vectors++; if ({bus.i_resp, bus.d_resp} !== exp_resp) begin errors++; $display("FAIL rr grant %0d resp: got %b want %b", n, {bus.i_resp, bus.d_resp}, exp_resp); end
            tick();
            bus.pmem_resp = 1'b0;
            #1;
            vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rr release %0d strobe: got %b want 0", n, bus.pmem_read); end
            tick();
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_addr_stable();
        bus.d_read = 1'b1; bus.d_address = 32'h0000_1000;
        tick();
        bus.d_address = 32'h0000_2000; bus.d_read = 1'b0;
        #1;
        vectors++; if (bus.pmem_address !== 32'h1000) begin errors++; $display("FAIL stable addr: got %h want 1000", bus.pmem_address); end
        vectors++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL stable strobe: got %b want 1", bus.pmem_read); end
        tick();
        vectors++; if (bus.pmem_address !== 32'h1000 || bus.pmem_read !== 1'b1) begin errors++; $display("FAIL stable hold: got addr %h rd %b want addr 1000 rd 1", bus.pmem_address, bus.pmem_read); end
        resp_on(LINE_55);
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin errors++; $display("FAIL stable resp: got %b want 01", {bus.i_resp, bus.d_resp}); end
        tick();
        bus.pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0080;
        tick();
        bus.d_read = 1'b1; bus.d_address = 32'h0000_3000;
        vectors++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h80) begin errors++; $display("FAIL rstmid pre: got rd %b addr %h want rd 1 addr 80", bus.pmem_read, bus.pmem_address); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rstmid async drop: got %b want 0", bus.pmem_read); end
        vectors++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL rstmid addr clear: got %h want 0", bus.pmem_address); end
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h3000) begin errors++; $display("FAIL rstmid D first: got rd %b addr %h want rd 1 addr 3000", bus.pmem_read, bus.pmem_address); end
        resp_on(LINE_C3);
        vectors++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin errors++; $display("FAIL rstmid D resp: got %b want 01", {bus.i_resp, bus.d_resp}); end
        tick();
        bus.pmem_resp = 1'b0; bus.d_read = 1'b0;
        tick();
        tick();
        vectors++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h80) begin errors++; $display("FAIL rstmid I regrant: got rd %b addr %h want rd 1 addr 80", bus.pmem_read, bus.pmem_address); end
        resp_on(LINE_17);
        vectors++; if (bus.i_rdata !== LINE_17 || bus.i_resp !== 1'b1) begin errors++; $display("FAIL rstmid I resp: got resp %b data %h want resp 1 data %h", bus.i_resp, bus.i_rdata, LINE_17); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_round_robin();
        test_addr_stable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
